// File: rtl/joint_step_feedback.sv
`default_nettype none
// ============================================================================
// Module   : joint_step_feedback
// Brief    : Step/dir position counter with host latch and step-period monitor.
// Revision : 1.0
// ============================================================================
module joint_step_feedback #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4800000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               STP,
  input  logic               DIR,
  input  logic               clearReq,
  input  logic               latchReq,
  output logic signed [31:0] jointFeedback,
  output logic signed [31:0] jointFeedbackLatched,
  output logic               latchValid,
  output logic        [31:0] stepPeriod,
  output logic               standstill
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               stp_prev;
  logic               step;
  logic signed [31:0] delta;
  logic signed [31:0] position;
  logic signed [31:0] position_next;
  logic        [31:0] period_cnt;
  logic        [31:0] period_cnt_next;
  logic        [31:0] step_period_next;
  logic               dir_last;
  logic               dir_last_next;
  logic               timeout_hit;

  assign step          = STP & ~stp_prev;
  assign delta         = step ? (DIR ? 32'sd1 : -32'sd1) : 32'sd0;
  // Clear only replaces the base, so a coincident step is still applied.
  assign position_next = (clearReq ? 32'sd0 : position) + delta;
  assign timeout_hit   = (period_cnt >= TIMEOUT_CYCLES);
  assign jointFeedback = position;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stp_prev             <= 1'b0;
      position             <= 32'sd0;
      jointFeedbackLatched <= 32'sd0;
      latchValid           <= 1'b0;
    end else begin
      stp_prev   <= STP;
      position   <= position_next;
      latchValid <= latchReq;
      if (latchReq) begin
        jointFeedbackLatched <= position_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= 32'd0;
      stepPeriod <= 32'd0;
      dir_last   <= 1'b0;
      standstill <= 1'b1;
    end else begin
      state      <= state_next;
      period_cnt <= period_cnt_next;
      stepPeriod <= step_period_next;
      dir_last   <= dir_last_next;
      standstill <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next       = state;
    period_cnt_next  = period_cnt;
    step_period_next = stepPeriod;
    dir_last_next    = dir_last;
    case (state)
      IDLE: begin
        if (step) begin
          state_next      = FIRST;
          period_cnt_next = 32'd1;
          dir_last_next   = DIR;
        end
      end
      FIRST, RUN: begin
        if (step) begin
          period_cnt_next = 32'd1;
          dir_last_next   = DIR;
          if (DIR == dir_last) begin
            state_next       = RUN;
            step_period_next = period_cnt;
          end else begin
            // A reversal invalidates the interval measured so far.
            state_next       = FIRST;
            step_period_next = 32'd0;
          end
        end else if (timeout_hit) begin
          state_next       = IDLE;
          step_period_next = 32'd0;
          period_cnt_next  = 32'd0;
        end else if (period_cnt != 32'hFFFF_FFFF) begin
          period_cnt_next = period_cnt + 32'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/joint_step_feedback.md
JOINT_STEP_FEEDBACK -- requirements
Module: joint_step_feedback

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd4800000, meaning the number of clocks without a counted step before the axis is declared standstill.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port STP, input, 1 bit: step signal from the joint stepper generator, same clock domain.
REQ-005 SHALL have port DIR, input, 1 bit: direction; 1 means positive, 0 means negative.
REQ-006 SHALL have port clearReq, input, 1 bit: single-cycle pulse that zeroes the position.
REQ-007 SHALL have port latchReq, input, 1 bit: single-cycle pulse that snapshots the position for host readback.
REQ-008 SHALL have port jointFeedback, output, signed 32 bits: live step position.
REQ-009 SHALL have port jointFeedbackLatched, output, signed 32 bits: position snapshot.
REQ-010 SHALL have port latchValid, output, 1 bit: one-cycle pulse when jointFeedbackLatched has updated.
REQ-011 SHALL have port stepPeriod, output, 32 bits: number of clocks between the last two same-direction counted steps; 0 when unknown.
REQ-012 SHALL have port standstill, output, 1 bit: high while no step has been counted within TIMEOUT_CYCLES.

Function
REQ-013 SHALL register STP once (stpPrev); a counted step is STP=1 and stpPrev=0, i.e. a rising edge only; falling edges are ignored.
REQ-014 SHALL sample DIR in the same cycle as the detected edge; delta is +1 if DIR=1, -1 if DIR=0, 0 if there is no edge.
REQ-015 SHALL update jointFeedback on the clock after the edge cycle (1-cycle latency from the STP rising edge) to jointFeedback+delta.
REQ-016 SHALL perform all position arithmetic as 32-bit two's complement, wrapping modulo 2^32: 32'h7FFFFFFF +1 gives 32'h80000000, and 32'h80000000 -1 gives 32'h7FFFFFFF; there is no saturation.
REQ-017 SHALL, on clearReq, set jointFeedback to 0+delta; a step coincident with clear is therefore retained, never lost.
REQ-018 SHALL, on latchReq, load jointFeedbackLatched with the same next value written to jointFeedback (including delta and any clear) and pulse latchValid high for exactly the following cycle.
REQ-019 SHALL, when latchReq and clearReq coincide, latch the post-clear value (delta).
REQ-020 SHALL hold jointFeedbackLatched constant when latchReq is low.
REQ-021 SHALL implement a measurement state machine with states IDLE, FIRST and RUN.
  - IDLE: a counted step moves to FIRST, loads periodCnt=1, and remembers the step direction.
  - FIRST: a same-direction step moves to RUN and sets stepPeriod=periodCnt, then periodCnt=1.
  - RUN: each same-direction step sets stepPeriod=periodCnt, then periodCnt=1.
  - FIRST or RUN: an opposite-direction step moves to FIRST, sets stepPeriod=0, sets periodCnt=1, and updates the remembered direction.
REQ-022 SHALL increment periodCnt by 1 on every clock without a counted step while in FIRST or RUN, saturating at 32'hFFFFFFFF.
REQ-023 SHALL, from FIRST or RUN, go to IDLE, set stepPeriod=0 and set standstill=1 when periodCnt reaches TIMEOUT_CYCLES with no step in that cycle; if a step coincides with that cycle, the step wins.
REQ-024 SHALL drive standstill=1 in IDLE and 0 in FIRST or RUN, registered.
REQ-025 SHALL leave the state machine and stepPeriod unaffected by clearReq.

Reset
REQ-026 SHALL, while rst=1, asynchronously force: jointFeedback=0, jointFeedbackLatched=0, latchValid=0, stepPeriod=0, standstill=1, state=IDLE, periodCnt=0, stpPrev=0.
REQ-027 SHALL treat STP=1 at reset release as a counted rising edge in the first active cycle, because stpPrev=0.
REQ-028 SHALL abandon any measurement in progress when reset is asserted mid-operation, with no partial update surviving.

Verification
REQ-029 Forward steps: DIR=1, 5 STP rising edges spaced 10 clocks -> jointFeedback=5, stepPeriod=10 after the 2nd edge, standstill=0.
REQ-030 Reversal: after REQ-029, DIR=0 and 3 edges spaced 8 clocks -> jointFeedback=2; stepPeriod=0 after the 1st reverse edge; stepPeriod=8 after the 2nd.
REQ-031 Wrap and clear: preload to 32'h7FFFFFFF via steps or a force, then 1 positive edge -> 32'h80000000; then clearReq coincident with a negative edge -> jointFeedback=32'hFFFFFFFF.
REQ-032 Latch: latchReq coincident with a +1 edge at position 41 -> jointFeedbackLatched=42, latchValid high exactly 1 cycle, and the latched value is stable afterwards while live steps continue.
REQ-033 Timeout: TIMEOUT_CYCLES=100, 2 edges spaced 20 clocks, then none -> standstill=1 and stepPeriod=0 exactly when periodCnt reaches 100; an edge landing on that cycle keeps the state RUN.
REQ-034 Async reset: assert rst mid-RUN between clock edges -> all outputs take reset values immediately, without waiting for a clock edge.
